// File: rtl/z_pipe_csel_adder.sv
// Pipelined N-bit add/subtract, one M-bit segment per stage, skewed in / deskewed out.
// Optional zero/neg flag outputs enabled by defining Z_PIPE_CSEL_FLAGS_EN.
module z_pipe_csel_adder #(
  parameter int N = 16,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         ovf
`ifdef Z_PIPE_CSEL_FLAGS_EN
  ,
  output logic         zero,
  output logic         neg
`endif
);

  localparam int S = N / M;

  if (N % M != 0) begin : g_bad_width
    $error("z_pipe_csel_adder: N must be a multiple of M");
  end

  logic         w_adv;
  logic         w_acc;
  logic [N-1:0] w_b_eff;
  logic         w_cin;

  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;
  assign w_acc    = in_valid & w_adv;
  assign w_b_eff  = sub ? ~b : b;
  assign w_cin    = sub | c_in;

  for (genvar k = 0; k < S; k++) begin : g_stg
    localparam int W = N - k * M;

    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic [N-1:0] w_s_in;
    logic [N-1:0] w_s_nx;
    logic         w_c_in;
    logic         w_v_in;
    logic [M:0]   w_seg;
    logic         r_v;
    logic [N-1:0] r_s;
    logic         r_c;
`ifdef Z_PIPE_CSEL_FLAGS_EN
    logic         w_z_in;
    logic         r_z;
`endif

    if (k == 0) begin : g_head
      assign w_a    = a;
      assign w_b    = w_b_eff;
      assign w_s_in = '0;
      assign w_c_in = w_cin;
      assign w_v_in = w_acc;
`ifdef Z_PIPE_CSEL_FLAGS_EN
      assign w_z_in = 1'b1;
`endif
    end else begin : g_body
      assign w_a    = g_stg[k-1].g_skew.r_a;
      assign w_b    = g_stg[k-1].g_skew.r_b;
      assign w_s_in = g_stg[k-1].r_s;
      assign w_c_in = g_stg[k-1].r_c;
      assign w_v_in = g_stg[k-1].r_v;
`ifdef Z_PIPE_CSEL_FLAGS_EN
      assign w_z_in = g_stg[k-1].r_z;
`endif
    end

    assign w_seg = {1'b0, w_a[M-1:0]}
                 + {1'b0, w_b[M-1:0]}
                 + {{M{1'b0}}, w_c_in};

    // Drop this stage's segment result into the deskewed sum word
    always_comb begin
      w_s_nx = w_s_in;
      w_s_nx[k*M +: M] = w_seg[M-1:0];
    end

    // Stage valid, partial sum and inter-segment carry
    always_ff @(posedge clk) begin
      if (rst) begin
        r_v <= 1'b0;
        r_s <= '0;
        r_c <= 1'b0;
      end else if (w_adv) begin
        r_v <= w_v_in;
        r_s <= w_s_nx;
        r_c <= w_seg[M];
      end
    end

`ifdef Z_PIPE_CSEL_FLAGS_EN
    // Zero flag accumulates one segment at a time
    always_ff @(posedge clk) begin
      if (rst) begin
        r_z <= 1'b0;
      end else if (w_adv) begin
        r_z <= w_z_in & (w_seg[M-1:0] == '0);
      end
    end
`endif

    if (k < S - 1) begin : g_skew
      logic [W-M-1:0] r_a;
      logic [W-M-1:0] r_b;

      // Carry the not-yet-added upper operand segments forward
      always_ff @(posedge clk) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_a[W-1:M];
          r_b <= w_b[W-1:M];
        end
      end
    end else begin : g_last
      logic r_ovf;

      // Signed overflow from the sign bits that rode the skew chain
      always_ff @(posedge clk) begin
        if (rst) begin
          r_ovf <= 1'b0;
        end else if (w_adv) begin
          r_ovf <= (w_a[W-1] == w_b[W-1]) &
                   (w_seg[M-1] != w_a[W-1]);
        end
      end
    end
  end

  assign out_valid = g_stg[S-1].r_v;
  assign sum       = g_stg[S-1].r_s;
  assign c_out     = g_stg[S-1].r_c;
  assign ovf       = g_stg[S-1].g_last.r_ovf;

`ifdef Z_PIPE_CSEL_FLAGS_EN
  assign zero = g_stg[S-1].r_z;
  assign neg  = sum[N-1];
`endif

endmodule

// File: doc/z_pipe_csel_adder.md
Name: z_pipe_csel_adder

Overview:
- Parametrised, pipelined successor to the team's m-bit adder stage.
- Splits an N-bit add/subtract into N/M segments of M bits, one segment per pipeline stage.
- Inter-segment carry is registered; operands and results are skewed and deskewed so each result emerges aligned.
- Valid/ready handshake with full backpressure; used as the arithmetic unit in the datapath.

Parameters:
- N, 16, total operand width; must be an integer multiple of M.
- M, 4, segment width (bits added per pipeline stage).
- S, N/M, derived stage count (localparam, not overridable); this is the latency in cycles.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  N  operand A.
- b  input  N  operand B.
- c_in  input  1  carry-in; used only when sub=0.
- sub  input  1  1 = A-B, 0 = A+B+c_in.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  N  result.
- c_out  output  1  carry out of bit N-1 (for sub: 1 = no borrow).
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset:
  - All stage valid bits clear; out_valid=0.
  - sum=0, c_out=0, ovf=0; in_ready=1 on the first cycle after reset.
  - Reset mid-operation discards all in-flight beats with no output.
- Operand conditioning at accept:
  - b_eff = sub ? ~b : b.
  - cin_eff = sub ? 1 : c_in.
- Stage k (0..S-1):
  - Adds a[kM+M-1:kM] + b_eff segment + carry from stage k-1 (stage 0 uses cin_eff).
  - Registers the M-bit segment sum and the carry-out.
  - Higher segments travel in skew registers until their stage; lower segment results are held in deskew registers.
- Latency: a beat accepted on cycle t is presented with out_valid=1 on cycle t+S, absent stalls.
- Advance condition: adv = ~out_valid | out_ready.
  - When adv=0, every stage register, skew register and valid bit holds.
  - in_ready = adv, combinational, no bubble.
  - Throughput is 1 beat/cycle when out_ready is held 1.
- Accept fires only when in_valid & in_ready; beats offered while in_ready=0 are not captured.
- Simultaneous output consume and input accept in the same cycle is legal; the pipeline shifts once.
- Output fields:
  - c_out = carry out of the final segment.
  - ovf = (a[N-1] == b_eff[N-1]) & (sum[N-1] != a[N-1]), computed with the sign bits delayed in step with the pipeline.
- Outputs stay stable while out_valid=1 and out_ready=0.
- Wrap-around: sums are modulo 2^N, and the carry is reported only on c_out.
- N % M != 0 is illegal; elaboration fails via a generate-time error.

Optional Feature:
- Macro Z_PIPE_CSEL_FLAGS_EN.
- Defined:
  - Adds two output ports: zero (1 bit, sum==0) and neg (1 bit, sum[N-1]).
  - Both are registered alongside sum, aligned to out_valid, and reset to 0.
  - zero is computed per segment and AND-accumulated through the pipeline, not by a final N-bit reduction.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Add with carry, N=16 M=4: a=0x1234, b=0x0FCC, c_in=1, sub=0, out_ready=1 -> 4 cycles later sum=0x2201, c_out=0, ovf=0.
- Full-carry ripple across all segments: a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1, ovf=0 (zero=1 with FLAGS_EN).
- Subtract and signed overflow:
  - a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, c_out=1, ovf=1.
  - a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, c_out=0, ovf=0 (neg=1 with FLAGS_EN).
- Back-to-back streaming: 8 consecutive beats with out_ready=1 -> 8 consecutive out_valid cycles, in order, first at t+4.
- Backpressure: fill the pipe, drop out_ready for 3 cycles -> in_ready=0, sum/out_valid held constant; on release, results drain with no loss or duplication.
- Reset mid-stream: assert rst with 3 beats in flight -> next cycle out_valid=0, sum=0; those beats never appear.
